// File: rtl/ide_pkg.sv
// Shared definitions for the IDE PIO sequencer: state encoding, default timing
// and counter widths.
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        WAIT_RDY,
        HOLD,
        RECOVER
    } ide_state_t;

    localparam int unsigned DEF_SETUP_CYC   = 1;
    localparam int unsigned DEF_ACTIVE_CYC  = 3;
    localparam int unsigned DEF_RECOVER_CYC = 2;
    localparam int unsigned DEF_RDY_TIMEOUT = 63;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with a configurable reset value, used for IORDY and
// IDEIRQ.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ide_pio_sequencer.sv
// Turns one decoded CPU access into a timed ATA PIO cycle (CS, setup, strobe, hold, recovery).
// Define IDE_IORDY_EN to build the IORDY wait state, its synchroniser and the rdy_timeout flag.
module ide_pio_sequencer
    import ide_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned ACTIVE_CYC  = DEF_ACTIVE_CYC,
    parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int unsigned RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic acc_req,
    input  logic acc_rw,
    input  logic acc_cs2,
    input  logic iordy,
    output logic IORDn,
    output logic IOWRn,
    output logic IDECS1n,
    output logic IDECS2n,
    output logic dtack_req,
    output logic busy,
    output logic rdy_timeout
);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(ACTIVE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    ide_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rw_q, rw_nxt;
    logic             cs2_q, cs2_nxt;
    logic             iordy_s;
    logic             cs_on, rd_on, wr_on;

`ifdef IDE_IORDY_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RDY_TIMEOUT - 1);

    logic [TMO_W-1:0] tcnt, tcnt_nxt;
    logic             tmo_set;

    sync2 #(.RST_VAL(1'b1)) u_iordy_sync (
        .clk   (cpu_clk),
        .rst_n (cpu_rstn),
        .d     (iordy),
        .q     (iordy_s)
    );
`else
    logic iordy_unused;

    assign iordy_unused = iordy;
    assign iordy_s      = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rw_nxt    = rw_q;
        cs2_nxt   = cs2_q;
`ifdef IDE_IORDY_EN
        tcnt_nxt  = tcnt;
        tmo_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (acc_req) begin
                    state_nxt = SETUP;
                    rw_nxt    = acc_rw;
                    cs2_nxt   = acc_cs2;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (!acc_req) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = RECOVER_LD;
                end else if (cnt == '0) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = ACTIVE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACTIVE: begin
                if (!acc_req) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = RECOVER_LD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (iordy_s) begin
                    state_nxt = HOLD;
                end
`ifdef IDE_IORDY_EN
                else begin
                    state_nxt = WAIT_RDY;
                    tcnt_nxt  = '0;
                end
`endif
            end
`ifdef IDE_IORDY_EN
            WAIT_RDY: begin
                if (!acc_req) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = RECOVER_LD;
                end else if (iordy_s) begin
                    state_nxt = HOLD;
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = HOLD;
                    tmo_set   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
`endif
            HOLD: begin
                if (!acc_req) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = RECOVER_LD;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe stays low through HOLD so data is valid while the CPU samples.
    assign cs_on = state inside {SETUP, ACTIVE, WAIT_RDY, HOLD};
    assign rd_on = rw_q && (state inside {ACTIVE, WAIT_RDY, HOLD});
    assign wr_on = !rw_q && (state inside {ACTIVE, WAIT_RDY});

    // Outputs decode the current state and land one edge later, so every pin is a flop.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            cs2_q     <= 1'b0;
            IORDn     <= 1'b1;
            IOWRn     <= 1'b1;
            IDECS1n   <= 1'b1;
            IDECS2n   <= 1'b1;
            dtack_req <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rw_q      <= rw_nxt;
            cs2_q     <= cs2_nxt;
            IORDn     <= ~rd_on;
            IOWRn     <= ~wr_on;
            IDECS1n   <= ~(cs_on & ~cs2_q);
            IDECS2n   <= ~(cs_on & cs2_q);
            dtack_req <= (state == HOLD);
            busy      <= (state != IDLE);
        end
    end

`ifdef IDE_IORDY_EN
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            tcnt        <= '0;
            rdy_timeout <= 1'b0;
        end else begin
            tcnt        <= tcnt_nxt;
            rdy_timeout <= rdy_timeout | tmo_set;
        end
    end
`else
    assign rdy_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Bench for ide_pio_sequencer: timestamp-based reference model checked every
// cycle, plus directed accesses with hand-computed edge timings.
`timescale 1ns/1ps
module tb_ide_pio_sequencer;

    localparam int SETUP_N   = 1;
    localparam int ACTIVE_N  = 3;
    localparam int RECOVER_N = 2;
    localparam int TMO_N     = 63;
    localparam int INF       = 1 << 30;
`ifdef IDE_IORDY_EN
    localparam bit IORDY_EN = 1'b1;
`else
    localparam bit IORDY_EN = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic cpu_rstn, acc_req, acc_rw, acc_cs2, iordy;
    logic IORDn, IOWRn, IDECS1n, IDECS2n, dtack_req, busy, rdy_timeout;

    int vecs  = 0;
    int fails = 0;

    ide_pio_sequencer #(
        .SETUP_CYC   (SETUP_N),
        .ACTIVE_CYC  (ACTIVE_N),
        .RECOVER_CYC (RECOVER_N),
        .RDY_TIMEOUT (TMO_N)
    ) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rstn    (cpu_rstn),
        .acc_req     (acc_req),
        .acc_rw      (acc_rw),
        .acc_cs2     (acc_cs2),
        .iordy       (iordy),
        .IORDn       (IORDn),
        .IOWRn       (IOWRn),
        .IDECS1n     (IDECS1n),
        .IDECS2n     (IDECS2n),
        .dtack_req   (dtack_req),
        .busy        (busy),
        .rdy_timeout (rdy_timeout)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Model: each access is described by the edge numbers at which it starts (s),
    // begins strobing (t_act), reaches HOLD (h) and starts recovery (r).
    int n = 0, first_edge = 0;
    int s = INF, h = INF, r = INF, t_act = INF, t_end = INF;
    bit in_txn = 1'b0, m_rw = 1'b0, m_cs2 = 1'b0, to_flag = 1'b0;
    bit raw_hist [0:4095];

    function automatic bit sync_at(input int k);
        if (k - 2 < first_edge) return 1'b1;
        return raw_hist[k - 2];
    endfunction

    always @(posedge cpu_clk) begin
        n = n + 1;
        if (n < 4096) raw_hist[n] = iordy;
        if (!cpu_rstn) begin
            in_txn = 1'b0; s = INF; h = INF; r = INF; t_act = INF; t_end = INF;
            to_flag = 1'b0; first_edge = n + 1;
        end else if (!in_txn) begin
            if (acc_req) begin
                in_txn = 1'b1; s = n; h = INF; r = INF;
                t_act = n + SETUP_N; t_end = t_act + ACTIVE_N;
                m_rw = acc_rw; m_cs2 = acc_cs2;
            end
        end else if (r == INF) begin
            if (!acc_req) r = n;
            else if (h == INF && n >= t_end) begin
                if (!IORDY_EN || sync_at(n)) h = n;
                else if (n - t_end == TMO_N) begin
                    h = n; to_flag = 1'b1;
                end
            end
        end else if (n == r + RECOVER_N) begin
            in_txn = 1'b0;
        end
    end

    // Outputs seen after edge n reflect the access phase held after edge n-1.
    always @(negedge cpu_clk) begin
        logic [6:0] got, exp;
        int  m;
        bit  cs_on, act_on;
        m = n - 1;
        got = {IORDn, IOWRn, IDECS1n, IDECS2n, dtack_req, busy, rdy_timeout};
        if (!cpu_rstn) begin
            exp = 7'b1111000;
        end else begin
            cs_on  = (m >= s) && (m < r);
            act_on = (m >= t_act) && (m < r);
            exp[6] = !(act_on && m_rw);
            exp[5] = !(act_on && (m < h) && !m_rw);
            exp[4] = !(cs_on && !m_cs2);
            exp[3] = !(cs_on && m_cs2);
            exp[2] = (m >= h) && (m < r);
            exp[1] = (m >= s) && (m < r + RECOVER_N);
            exp[0] = to_flag;
        end
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL cycle_compare edge %0d: got %b expected %b (IORDn IOWRn CS1n CS2n dtack busy tmo)",
                     n, got, exp);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts an access at a negedge; k counts samples taken after edge e0+k.
    // drop_k < 0 means release acc_req three samples after dtack_req is seen.
    task automatic access(input bit rw, input bit cs2, input int drop_k,
                          input int lo_from, input int lo_to,
                          output int t_cs, output int t_str, output int t_dt,
                          output int n_str, output int t_rel, output int t_idle,
                          output bit other_cs);
        int  k, drop_at;
        bit  dropped;
        logic cs_sel, cs_oth, strobe;
        t_cs = -1; t_str = -1; t_dt = -1; n_str = 0; t_rel = -1; t_idle = -1;
        other_cs = 1'b0; dropped = 1'b0; drop_at = drop_k;
        acc_rw = rw; acc_cs2 = cs2; acc_req = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge cpu_clk);
            cs_sel = cs2 ? IDECS2n : IDECS1n;
            cs_oth = cs2 ? IDECS1n : IDECS2n;
            strobe = rw ? IORDn : IOWRn;
            if (!cs_sel && t_cs < 0) t_cs = k;
            if (!cs_oth) other_cs = 1'b1;
            if (!strobe) begin
                n_str++;
                if (t_str < 0) t_str = k;
            end
            if (dtack_req && t_dt < 0) begin
                t_dt = k;
                if (drop_k < 0) drop_at = k + 3;
            end
            if (dropped && t_rel < 0 && IORDn && IOWRn && IDECS1n && IDECS2n && !dtack_req)
                t_rel = k;
            if (dropped && !busy) begin
                t_idle = k;
                break;
            end
            if (k == lo_from) iordy = 1'b0;
            if (k == lo_to) iordy = 1'b1;
            if (k == drop_at) begin
                acc_req = 1'b0;
                dropped = 1'b1;
            end
        end
        acc_req = 1'b0;
        iordy   = 1'b1;
        if (t_idle < 0) check("access_completes", 0, 1);
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $fatal(1);
    end

    initial begin
        int  t_cs, t_str, t_dt, n_str, t_rel, t_idle, kb, kc;
        bit  oth;
        cpu_rstn = 1'b0; acc_req = 1'b0; acc_rw = 1'b0; acc_cs2 = 1'b0; iordy = 1'b1;
        repeat (3) @(negedge cpu_clk);
        check("reset_outputs", int'({IORDn, IOWRn, IDECS1n, IDECS2n, dtack_req, busy, rdy_timeout}),
              int'(7'b1111000));
        cpu_rstn = 1'b1;
        repeat (3) @(negedge cpu_clk);

        // Read, CS1, iordy high, acc_req released after sample 9 (seen at edge 10).
        access(1'b1, 1'b0, 9, -1, -1, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("rd_cs1_at", t_cs, 1);
        check("rd_strobe_at", t_str, 2);
        check("rd_dtack_at", t_dt, 5);
        check("rd_strobe_len", n_str, 9);
        check("rd_release_at", t_rel, 11);
        check("rd_idle_at", t_idle, 13);
        check("rd_cs2_seen", int'(oth), 0);
        repeat (2) @(negedge cpu_clk);

        // Write, CS2: IOWRn low exactly 3 clocks and high once dtack_req rises.
        access(1'b0, 1'b1, 7, -1, -1, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("wr_cs2_at", t_cs, 1);
        check("wr_strobe_at", t_str, 2);
        check("wr_strobe_len", n_str, 3);
        check("wr_dtack_at", t_dt, 5);
        check("wr_cs1_seen", int'(oth), 0);
        repeat (2) @(negedge cpu_clk);

        // iordy low on raw edges 2..13, seen by the sequencer on edges 4..15.
        access(1'b1, 1'b0, -1, 1, 13, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("iordy_dtack_at", t_dt, IORDY_EN ? 17 : 5);
        check("iordy_no_timeout", int'(rdy_timeout), 0);
        repeat (2) @(negedge cpu_clk);

        // iordy stuck low: forced completion 63 clocks beyond nominal.
        access(1'b1, 1'b0, -1, 1, 100000, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("stuck_dtack_at", t_dt, IORDY_EN ? 68 : 5);
        check("stuck_timeout_set", int'(rdy_timeout), int'(IORDY_EN));
        repeat (2) @(negedge cpu_clk);
        access(1'b0, 1'b0, 6, -1, -1, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("next_dtack_at", t_dt, 5);
        check("timeout_sticky", int'(rdy_timeout), int'(IORDY_EN));
        @(negedge cpu_clk);
        cpu_rstn = 1'b0;
        @(negedge cpu_clk);
        check("timeout_cleared", int'(rdy_timeout), 0);
        cpu_rstn = 1'b1;
        repeat (2) @(negedge cpu_clk);

        // Abort during SETUP: CS pulses once, no strobe, no dtack.
        access(1'b1, 1'b0, 0, -1, -1, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("abort_cs_at", t_cs, 1);
        check("abort_strobe_at", t_str, -1);
        check("abort_dtack_at", t_dt, -1);
        check("abort_release_at", t_rel, 2);
        check("abort_idle_at", t_idle, 4);
        repeat (2) @(negedge cpu_clk);

        // Request re-raised during RECOVER is taken only once back in IDLE.
        acc_rw = 1'b0; acc_cs2 = 1'b1; acc_req = 1'b1;
        @(negedge cpu_clk);
        acc_req = 1'b0;
        @(negedge cpu_clk);
        acc_req = 1'b1;
        kb = -1; kc = -1;
        for (int k = 2; k < 20; k++) begin
            @(negedge cpu_clk);
            if (!busy && kb < 0) kb = k;
            if (!IDECS2n && kc < 0) kc = k;
        end
        check("b2b_busy_low_at", kb, 4);
        check("b2b_cs2_at", kc, 5);
        acc_req = 1'b0;
        repeat (8) @(negedge cpu_clk);

        // Asynchronous reset while waiting for IORDY releases everything before the next edge.
        acc_rw = 1'b1; acc_cs2 = 1'b0; acc_req = 1'b1;
        repeat (2) @(negedge cpu_clk);
        iordy = 1'b0;
        repeat (7) @(negedge cpu_clk);
        check("wait_iord_low", int'(IORDn), 0);
        check("wait_dtack", int'(dtack_req), IORDY_EN ? 0 : 1);
        @(posedge cpu_clk);
        #1 cpu_rstn = 1'b0;
        #1;
        check("rst_async_iord", int'(IORDn), 1);
        check("rst_async_cs1", int'(IDECS1n), 1);
        check("rst_async_dtack", int'(dtack_req), 0);
        check("rst_async_busy", int'(busy), 0);
        @(negedge cpu_clk);
        acc_req = 1'b0; iordy = 1'b1;
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        repeat (2) @(negedge cpu_clk);

        access(1'b1, 1'b1, 6, -1, -1, t_cs, t_str, t_dt, n_str, t_rel, t_idle, oth);
        check("post_rst_dtack_at", t_dt, 5);
        repeat (3) @(negedge cpu_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/ide_pio_sequencer.md
Name: ide_pio_sequencer

Overview:
- Sits between the IDE address decode and the IDE connector.
- Turns one decoded CPU access to the IDE window into a timed ATA PIO cycle: chip selects, then a setup phase, then an IORDn/IOWRn strobe, then recovery.
- Samples IORDY to extend the strobe and returns a DTACK request to the board top level.
- Replaces the purely combinational strobe generation, so slow drives meet PIO mode-0 timing at 7.09 MHz CPU clock.

Parameters:
- SETUP_CYC, 1, clocks from chip-select assertion to strobe assertion (1..7).
- ACTIVE_CYC, 3, minimum clocks with the strobe asserted (1..15).
- RECOVER_CYC, 2, clocks with strobes and chip selects deasserted before the next cycle may start (1..7).
- RDY_TIMEOUT, 63, maximum extra clocks spent waiting for IORDY before forced completion (1..255).

Ports:
- cpu_clk  in  1  CPU clock
- cpu_rstn  in  1  asynchronous active-low reset
- acc_req  in  1  decoded IDE access, level: IDE window hit AND address strobe asserted
- acc_rw  in  1  1 = read, 0 = write; sampled when a cycle starts
- acc_cs2  in  1  1 = CS2 register bank, 0 = CS1 bank; sampled when a cycle starts
- iordy  in  1  IORDY from the drive, asynchronous
- IORDn  out  1  IDE read strobe, active low
- IOWRn  out  1  IDE write strobe, active low
- IDECS1n  out  1  chip select 1, active low
- IDECS2n  out  1  chip select 2, active low
- dtack_req  out  1  request to the top level to drive DTACKn low
- busy  out  1  high in every state except IDLE
- rdy_timeout  out  1  sticky flag: an IORDY wait timed out; cleared only by reset

Behaviour:
- All outputs are registered.
- Reset values: IORDn=1, IOWRn=1, IDECS1n=1, IDECS2n=1, dtack_req=0, busy=0, rdy_timeout=0, state=IDLE.
- Reset is asynchronous, so asserting it mid-cycle releases all strobes immediately.
- iordy passes through a 2-flop synchroniser (reset value 1) before use.
- IDLE → SETUP:
  - Taken on a clock where acc_req=1.
  - Latch acc_rw and acc_cs2; assert the selected CS on the next edge.
  - Load the counter with SETUP_CYC-1.
- SETUP → ACTIVE:
  - Taken when the counter reaches 0.
  - Assert IORDn (read) or IOWRn (write); load the counter with ACTIVE_CYC-1.
- ACTIVE:
  - Stay while the counter is nonzero.
  - At counter 0: go to HOLD if synchronised iordy=1, otherwise to WAIT_RDY with the timeout counter cleared.
- WAIT_RDY:
  - Strobe stays asserted; the timeout counter increments each clock.
  - iordy=1 → HOLD.
  - Counter reaching RDY_TIMEOUT → set rdy_timeout, go to HOLD.
- HOLD:
  - dtack_req=1.
  - Read: IORDn stays low so data remains valid while the CPU samples.
  - Write: IOWRn deasserts on entry to HOLD; CS and the bus write data are held by the CPU.
  - Remain in HOLD until acc_req=0.
- RECOVER:
  - Entered from HOLD when acc_req falls.
  - All strobes, CS and dtack_req deasserted on the same edge.
  - Counter loaded with RECOVER_CYC-1; → IDLE at counter 0.
  - A request arriving during RECOVER is not accepted until IDLE; acc_req is a level, so it is picked up then.
- Abort: acc_req falling in SETUP, ACTIVE or WAIT_RDY → RECOVER immediately. No dtack_req is issued, and rdy_timeout is unaffected.
- Latency, SETUP=1, ACTIVE=3, iordy high:
  - acc_req seen at edge 0.
  - CS low after edge 1.
  - Strobe low after edge 2.
  - dtack_req high after edge 5.
- acc_req held high after DTACK does not retrigger; a new cycle needs a falling edge, through RECOVER, before the next one starts.
- Only one CS is ever asserted at a time; IORDn and IOWRn are never both low.

Optional Feature:
- Macro: IDE_IORDY_EN.
- Defined: WAIT_RDY state, iordy synchroniser and rdy_timeout logic are present, exactly as described above.
- Undefined:
  - iordy is ignored and ACTIVE always proceeds straight to HOLD.
  - WAIT_RDY and the timeout counter are not built.
  - rdy_timeout is tied to 0.
  - The iordy port remains, so top-level wiring is unchanged.

Decomposition:
- Shared package ide_pkg holds:
  - the state encoding typedef (IDLE, SETUP, ACTIVE, WAIT_RDY, HOLD, RECOVER);
  - default timing constants;
  - the counter width constant (4 bits, timeout counter 8 bits).
- One natural sub-module: sync2, a 2-flop synchroniser with configurable reset value, reused for iordy and IDEIRQ.

Test Plan:
- Read, defaults, iordy=1, acc_req held 10 clocks, acc_cs2=0 → IDECS1n low at edge 1, IORDn low edges 2..(release), dtack_req high at edge 5, all inactive 1 edge after acc_req falls, busy low 2 clocks later.
- Write with acc_cs2=1 → IDECS2n low, IOWRn low for exactly 3 clocks, IOWRn high when dtack_req rises, IDECS1n never low.
- iordy low 10 clocks into ACTIVE, IDE_IORDY_EN defined → dtack_req delayed 10+2 clocks (synchroniser) beyond nominal, rdy_timeout stays 0.
- iordy stuck low, RDY_TIMEOUT=63 → dtack_req at nominal+63 clocks, rdy_timeout=1 and stays set across further cycles until cpu_rstn pulse.
- acc_req drops during SETUP → strobe never asserted, dtack_req never asserted, RECOVER then IDLE; back-to-back acc_req during RECOVER starts its cycle only after busy=0.
- cpu_rstn asserted during WAIT_RDY → IORDn, CSs high and dtack_req low asynchronously, before the next clock edge.
